// File: rtl/reg_file_sb_if.sv
// Decode/issue/writeback bundle for the register file with busy scoreboard.
// The core drives the master side; the register file sits on the slave side.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   src1_reg;
  logic [AW-1:0]   src2_reg;
  logic [XLEN-1:0] src1_reg_value;
  logic [XLEN-1:0] src2_reg_value;
  logic            src1_busy;
  logic            src2_busy;
  logic            reg_write_control;
  logic [AW-1:0]   dest_reg;
  logic [XLEN-1:0] reg_write_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_reg;
  logic [AW:0]     busy_count;

  modport master (
    output src1_reg, src2_reg, reg_write_control, dest_reg, reg_write_data,
           issue_valid, issue_reg,
    input  src1_reg_value, src2_reg_value, src1_busy, src2_busy, busy_count
  );

  modport slave (
    input  src1_reg, src2_reg, reg_write_control, dest_reg, reg_write_data,
           issue_valid, issue_reg,
    output src1_reg_value, src2_reg_value, src1_busy, src2_busy, busy_count
  );
endinterface

// File: rtl/reg_file_sb.sv
// XLEN x NREGS register file, 2 comb read ports, 1 write port, per-register busy scoreboard; no backpressure.
// Writes/issues land at the clock edge; REGFILE_BYPASS_EN forwards writeback data/busy-clear to reads in the same cycle.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_count;

  logic w_wr_en;
  logic w_iss_en;
  logic w_same_reg;
  logic w_inc;
  logic w_dec;

  assign w_wr_en    = bus.reg_write_control && (bus.dest_reg != '0);
  assign w_iss_en   = bus.issue_valid && (bus.issue_reg != '0);
  assign w_same_reg = w_iss_en && w_wr_en && (bus.issue_reg == bus.dest_reg);

  // Issue beats writeback on the same register, so that case never decrements.
  assign w_inc = w_iss_en && !r_busy[bus.issue_reg];
  assign w_dec = w_wr_en && r_busy[bus.dest_reg] && !w_same_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[bus.dest_reg] <= bus.reg_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_busy[bus.dest_reg] <= 1'b0;
      end
      // Later assignment wins when both target the same bit.
      if (w_iss_en) begin
        r_busy[bus.issue_reg] <= 1'b1;
      end
      r_busy_count <= r_busy_count + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end

  assign bus.busy_count = r_busy_count;

  always_comb begin
    bus.src1_reg_value = r_regs[bus.src1_reg];
    bus.src1_busy      = r_busy[bus.src1_reg];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (bus.src1_reg == bus.dest_reg)) begin
      bus.src1_reg_value = bus.reg_write_data;
      if (!(w_iss_en && (bus.issue_reg == bus.src1_reg))) begin
        bus.src1_busy = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    bus.src2_reg_value = r_regs[bus.src2_reg];
    bus.src2_busy      = r_busy[bus.src2_reg];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (bus.src2_reg == bus.dest_reg)) begin
      bus.src2_reg_value = bus.reg_write_data;
      if (!(w_iss_en && (bus.issue_reg == bus.src2_reg))) begin
        bus.src2_busy = 1'b0;
      end
    end
`endif
  end
endmodule
